// File: rtl/program_run_monitor.sv
// program_run_monitor: sequences the core's resetl/startpc, watches currentpc for the end address and checks MemtoRegOut.
// Optional trace outputs are enabled by defining RUN_MON_TRACE_EN.
module program_run_monitor #(
    parameter logic [63:0] END_PC       = 64'h34,
    parameter logic [63:0] EXPECTED     = 64'h123456789abcdef0,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT   = 16'hFF
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] start_pc_in,
    output logic        resetl,
    output logic [63:0] startpc,
    input  logic [63:0] currentpc,
    input  logic [63:0] MemtoRegOut,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] cycle_count,
    output logic [63:0] result
`ifdef RUN_MON_TRACE_EN
    ,
    output logic        trace_valid,
    output logic [63:0] trace_pc,
    output logic [63:0] trace_data
`endif
);
    typedef enum logic [2:0] {IDLE, HOLD_RST, RUN, CHECK, DONE} state_t;
    localparam logic [7:0]  HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);
    state_t      state, state_n;
    logic [7:0]  hold_cnt, hold_n;
    logic [63:0] startpc_n, result_n;
    logic        pass_n, timeout_n;
    logic [15:0] count_n;
    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        startpc_n = startpc;
        result_n  = result;
        pass_n    = pass;
        timeout_n = timeout;
        count_n   = cycle_count;
        case (state)
            IDLE, DONE: if (start) begin
                state_n   = HOLD_RST;
                startpc_n = start_pc_in;
                hold_n    = 8'd0;
                count_n   = 16'd0;
                result_n  = 64'd0;
                pass_n    = 1'b0;
                timeout_n = 1'b0;
            end
            HOLD_RST: begin
                hold_n  = hold_cnt + 8'd1;
                state_n = (hold_cnt == HOLD_LAST) ? RUN : HOLD_RST;
            end
            RUN: begin
                count_n = cycle_count + 16'(cycle_count != 16'hFFFF);
                // end-PC is tested first so it wins over a coincident watchdog expiry
                if (currentpc >= END_PC) state_n = CHECK;
                else if (cycle_count == WDOG_LAST) begin
                    state_n   = DONE;
                    timeout_n = 1'b1;
                    pass_n    = 1'b0;
                    result_n  = MemtoRegOut;
                end
            end
            CHECK: begin
                state_n  = DONE;
                result_n = MemtoRegOut;
                pass_n   = (MemtoRegOut == EXPECTED);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= 8'd0;
            resetl      <= 1'b0;
            startpc     <= 64'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= 16'd0;
            result      <= 64'd0;
        end else begin
            state       <= state_n;
            hold_cnt    <= hold_n;
            resetl      <= (state_n == RUN) || (state_n == CHECK);
            startpc     <= startpc_n;
            busy        <= (state_n == HOLD_RST) || (state_n == RUN) || (state_n == CHECK);
            done        <= (state_n == DONE);
            pass        <= pass_n;
            timeout     <= timeout_n;
            cycle_count <= count_n;
            result      <= result_n;
        end
    end
`ifdef RUN_MON_TRACE_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= 64'd0;
            trace_data  <= 64'd0;
        end else begin
            trace_valid <= (state == RUN) || (state == CHECK);
            trace_pc    <= currentpc;
            trace_data  <= MemtoRegOut;
        end
    end
`endif
endmodule

// File: tb/tb_program_run_monitor.sv
// tb_program_run_monitor: behavioural core plus scoreboard of expected run outcomes for program_run_monitor.
module tb_program_run_monitor;
    localparam logic [63:0] EXP_VAL = 64'h123456789abcdef0;
    logic        CLK = 1'b0, reset = 1'b1, start = 1'b0;
    logic [63:0] start_pc_in = 64'd0;
    logic        resetl, busy, done, pass, timeout;
    logic [63:0] startpc, currentpc, MemtoRegOut, result;
    logic [15:0] cycle_count;
    int checks = 0, errors = 0;
    int mode = 0;
    logic [63:0] final_val = 64'd0;
    logic [15:0] ccyc = 16'd0;
    typedef struct {
        logic        p;
        logic        t;
        logic [15:0] c;
        logic [63:0] r;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    // behavioural core: ccyc counts cycles since resetl was released
    always @(posedge CLK) ccyc <= !resetl ? 16'd0 : ccyc + 16'd1;
    always_comb begin
        currentpc   = (mode == 0) ? startpc + 64'(ccyc) * 64'd4 :
                      (mode == 1) ? 64'h10 :
                      (ccyc >= 16'd254) ? 64'h34 : 64'h10;
        MemtoRegOut = (currentpc >= 64'h34) ? final_val : 64'hDEAD;
    end

`ifdef RUN_MON_TRACE_EN
    logic        trace_valid;
    logic [63:0] trace_pc, trace_data;
    int          tv_cnt = 0;
    logic [63:0] tv_first = 64'd0;
    always @(posedge CLK) if (trace_valid) begin
        if (tv_cnt == 0) tv_first = trace_pc;
        tv_cnt++;
    end
`endif

    program_run_monitor dut (
        .CLK(CLK), .reset(reset), .start(start), .start_pc_in(start_pc_in),
        .resetl(resetl), .startpc(startpc), .currentpc(currentpc), .MemtoRegOut(MemtoRegOut),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .cycle_count(cycle_count), .result(result)
`ifdef RUN_MON_TRACE_EN
        , .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_data(trace_data)
`endif
    );

    task automatic do_run(input logic [63:0] spc, input int m, input logic [63:0] fv,
                          input logic ep, input logic et, input logic [15:0] ec);
        exp_t e, g;
        int low, n;
        e.p = ep; e.t = et; e.c = ec;
        e.r = et ? 64'hDEAD : fv;
        e.lat = et ? int'(ec) : int'(ec) + 1;
        sb.push_back(e);
        mode = m; final_val = fv;
        start = 1'b1; start_pc_in = spc;
        @(posedge CLK); #1;
        start = 1'b0;
`ifdef RUN_MON_TRACE_EN
        tv_cnt = 0;
`endif
        checks++;
        if ({busy, done, resetl} !== 3'b100) begin
            errors++; $display("FAIL start_flags: busy/done/resetl got %b expected 100", {busy, done, resetl});
        end
        checks++;
        if (startpc !== spc) begin
            errors++; $display("FAIL startpc: got %h expected %h", startpc, spc);
        end
        low = 1;
        while (!resetl && low < 50) begin
            @(posedge CLK); #1;
            if (!resetl) low++;
        end
        checks++;
        if (low != 2) begin
            errors++; $display("FAIL resetl_low: got %0d cycles expected 2", low);
        end
        n = 0;
        while (!done && n < 1000) begin
            @(posedge CLK); #1;
            n++;
        end
        g = sb.pop_front();
        checks++;
        if (!done) begin
            errors++; $display("FAIL done_wait: got done=%b after %0d cycles expected 1", done, n);
        end
        checks++;
        if (n != g.lat) begin
            errors++; $display("FAIL done_latency: got %0d expected %0d", n, g.lat);
        end
        checks++;
        if ({pass, timeout} !== {g.p, g.t}) begin
            errors++; $display("FAIL pass_timeout: got %b%b expected %b%b", pass, timeout, g.p, g.t);
        end
        checks++;
        if (cycle_count !== g.c) begin
            errors++; $display("FAIL cycle_count: got %0d expected %0d", cycle_count, g.c);
        end
        checks++;
        if (result !== g.r) begin
            errors++; $display("FAIL result: got %h expected %h", result, g.r);
        end
        checks++;
        if ({resetl, busy} !== 2'b00) begin
            errors++; $display("FAIL parked: resetl/busy got %b expected 00", {resetl, busy});
        end
`ifdef RUN_MON_TRACE_EN
        if (!g.t) begin
            checks++;
            if (tv_cnt != int'(g.c) + 1) begin
                errors++; $display("FAIL trace_count: got %0d expected %0d", tv_cnt, int'(g.c) + 1);
            end
            checks++;
            if (mode == 0 && tv_first !== spc) begin
                errors++; $display("FAIL trace_first_pc: got %h expected %h", tv_first, spc);
            end
        end
`endif
        repeat (2) @(posedge CLK); #1;
        checks++;
        if ({done, pass, timeout, result} !== {1'b1, g.p, g.t, g.r}) begin
            errors++; $display("FAIL done_hold: got done=%b pass=%b timeout=%b result=%h", done, pass, timeout, result);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge CLK); #1;
        checks++;
        if ({resetl, busy, done, pass, timeout} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {resetl, busy, done, pass, timeout});
        end
        checks++;
        if ({startpc, cycle_count, result} !== 144'd0) begin
            errors++; $display("FAIL reset_data: got startpc=%h count=%0d result=%h expected 0", startpc, cycle_count, result);
        end
        reset = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_pass_run();
        do_run(64'h0, 0, EXP_VAL, 1'b1, 1'b0, 16'd14);
    endtask

    task automatic test_fail_run();
        do_run(64'h0, 0, 64'hF, 1'b0, 1'b0, 16'd14);
    endtask

    task automatic test_timeout();
        do_run(64'h0, 1, EXP_VAL, 1'b0, 1'b1, 16'hFF);
    endtask

    task automatic test_endpc_priority();
        do_run(64'h0, 2, EXP_VAL, 1'b1, 1'b0, 16'hFF);
    endtask

    task automatic test_ignore_and_reset();
        logic [15:0] cc;
        mode = 1;
        start = 1'b1; start_pc_in = 64'h40;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK); #1;
        cc = cycle_count;
        start = 1'b1; start_pc_in = 64'h100;
        @(posedge CLK); #1;
        start = 1'b0;
        checks++;
        if ({busy, resetl, startpc} !== {2'b11, 64'h40}) begin
            errors++; $display("FAIL start_ignored: got busy=%b resetl=%b startpc=%h expected 1 1 40", busy, resetl, startpc);
        end
        checks++;
        if (cycle_count !== cc + 16'd1) begin
            errors++; $display("FAIL run_count: got %0d expected %0d", cycle_count, cc + 16'd1);
        end
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        checks++;
        if ({resetl, busy, done, pass, timeout, startpc, cycle_count, result} !== 149'd0) begin
            errors++; $display("FAIL midrun_reset: got resetl=%b busy=%b done=%b startpc=%h count=%0d expected all 0", resetl, busy, done, startpc, cycle_count);
        end
        do_run(64'h8, 0, EXP_VAL, 1'b1, 1'b0, 16'd12);
    endtask

    task automatic test_back_to_back();
        do_run(64'h0, 0, 64'h55, 1'b0, 1'b0, 16'd14);
        do_run(64'h0, 0, EXP_VAL, 1'b1, 1'b0, 16'd14);
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_fail_run();
        test_timeout();
        test_endpc_priority();
        test_ignore_and_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_run_monitor.md
# program_run_monitor

Synthesizable run controller and result checker for the `singlecycle` processor: on a start pulse it drives the processor's `resetl`/`startpc` inputs through a reset sequence and releases the core. It then watches `currentpc` until the program reaches its end address, captures `MemtoRegOut`, and reports pass/fail against an expected value. A cycle watchdog is included. The block sits beside the core at the top level, on the other end of the processor's control/observation interface.

## Interface
- `END_PC`, 64'h34: program end address; run ends when `currentpc >= END_PC` (unsigned).
- `EXPECTED`, 64'h123456789abcdef0: required `MemtoRegOut` at end of run.
- `RESET_CYCLES`, 2: cycles `resetl` is held low per run; legal range 1..255.
- `WDOG_LIMIT`, 16'hFF: RUN cycles allowed before timeout; legal range 1..65535.

Ports:
- `CLK`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  run request, sampled each posedge.
- `start_pc_in`  in  64  start address, latched when `start` is accepted.
- `resetl`  out  1  active-low reset to the processor.
- `startpc`  out  64  start address to the processor.
- `currentpc`  in  64  processor PC.
- `MemtoRegOut`  in  64  processor writeback value.
- `busy`  out  1  high in HOLD_RST, RUN and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`; captured result equals `EXPECTED`.
- `timeout`  out  1  valid when `done`; watchdog expired.
- `cycle_count`  out  16  RUN cycles of the current/last run.
- `result`  out  64  captured `MemtoRegOut`.

## Operation
- States: IDLE, HOLD_RST, RUN, CHECK, DONE.
- IDLE: `resetl`=0. `start`=1 → latch `start_pc_in` into `startpc`, clear `pass`/`timeout`/`cycle_count`/`result` and the hold counter, go to HOLD_RST.
- HOLD_RST: `resetl`=0. Hold counter increments each cycle. After `RESET_CYCLES` cycles in this state → RUN.
- RUN: `resetl`=1. `cycle_count` increments each cycle, saturating at 16'hFFFF.
  - `currentpc >= END_PC` → CHECK.
  - Otherwise, if `cycle_count == WDOG_LIMIT-1` this cycle → DONE with `timeout`=1, `pass`=0, and `result` ← `MemtoRegOut`.
  - End-PC and watchdog in the same cycle: end-PC wins; `timeout` stays 0.
- CHECK: `resetl`=1. `result` ← `MemtoRegOut`; `pass` ← (`MemtoRegOut == EXPECTED`). Go to DONE.
- DONE: `resetl`=0 (core parked); flags and `result` held. `start`=1 behaves as in IDLE.
- `start` in HOLD_RST, RUN or CHECK is ignored; there is no abort.
- `startpc` holds its latched value until the next accepted `start`.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `resetl`=0, `startpc`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `cycle_count`=0, `result`=0.
- `reset` has priority over everything, including mid-run; the core sees `resetl`=0 on the next cycle.
- `start` at posedge N → HOLD_RST and `busy`=1 from N+1. `resetl` rises at N+1+`RESET_CYCLES`.
- End-PC first seen at posedge M in RUN → CHECK at M+1. `done`, `pass` and `result` are valid from M+2, and `resetl` falls at M+2.
- Timeout: `done`=1 and `timeout`=1 are visible the cycle after the `WDOG_LIMIT`-th RUN cycle; `cycle_count`=`WDOG_LIMIT` at that point.
- `done` is a level, not a pulse; it clears the cycle after an accepted `start`.

## Configuration
- `RUN_MON_TRACE_EN` defined: adds output ports `trace_valid` (1), `trace_pc` (64) and `trace_data` (64). Each RUN or CHECK cycle, they present `currentpc` and `MemtoRegOut` registered one cycle later, with `trace_valid`=1. `trace_valid`=0 in all other states and on reset; data resets to 0.
- Not defined: the trace ports and their registers are absent; all other behaviour is identical.

## Test plan
- Reset then `start` with `start_pc_in`=0. Behavioural core increments PC by 4 per cycle and presents 64'h123456789abcdef0 at PC 0x34 → `resetl` low exactly 2 cycles; `done`=1, `pass`=1, `timeout`=0, `result`=64'h123456789abcdef0, `cycle_count`=14.
- Same run, but the core presents 64'hF at PC 0x34 → `done`=1, `pass`=0, `result`=64'hF.
- Core PC stuck at 0x10 → `timeout`=1, `pass`=0, `cycle_count`=16'hFF; `resetl`=0 after `done`.
- Core reaches PC 0x34 exactly on the 255th RUN cycle → `timeout`=0 and CHECK is entered (end-PC priority).
- `start` pulsed during RUN is ignored. `reset` asserted mid-RUN → the next cycle shows IDLE, all outputs at reset values and `resetl`=0. A following `start` with `start_pc_in`=0x8 gives `startpc`=0x8.
- With `RUN_MON_TRACE_EN` defined: `trace_valid` is high for exactly `cycle_count`+1 cycles per run, and the first `trace_pc` equals the core's first PC after `resetl` rises.
